basilisk_writeback: RTL and testbench

- Final stage of the basilisk FPU datapath.
- Collects results from the add, mult(/macc), divide and sqrt pipelines (basilisk_result_t, unrounded) plus one pre-encoded stream from convert/memory (basilisk_writeback_result_t).
- Round-robin arbitrates between them, rounds FPU results to IEEE-754 single, and presents one registered basilisk_writeback_result_t per cycle to the float register-file write port.

---
 rtl/basilisk_writeback_pkg.sv | 94 +++++++++
 rtl/basilisk_writeback_arbiter.sv | 40 ++++
 rtl/basilisk_writeback.sv | 101 ++++++++++
 tb/tb_basilisk_writeback.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/basilisk_writeback_pkg.sv
// Shared types for the basilisk FPU writeback stage: result formats, exception flags and the
// IEEE-754 single-precision rounding helpers reused by the encode stage.
package basilisk_writeback_pkg;

  localparam int unsigned BASILISK_WRITEBACK_INPUTS = 5;
  localparam int unsigned STREAM_DIV = 2;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef logic [31:0] rv32_reg_value_t;

  typedef struct packed {
    logic [4:0]  dest_reg_addr;
    logic [1:0]  dest_offset_addr;
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
    logic        guard;
    logic        round_bit;
    logic        sticky;
    logic [2:0]  round_mode;
    logic        is_nan;
    logic        is_snan;
    logic        div_zero;
  } basilisk_result_t;

  typedef basilisk_result_t fpu_result_t;

  typedef struct packed {
    logic [4:0]      dest_reg_addr;
    logic [1:0]      dest_offset_addr;
    rv32_reg_value_t value;
  } basilisk_writeback_result_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } basilisk_fflags_t;

  function automatic logic basilisk_round_up(fpu_result_t r);
    logic inexact;
    inexact = r.guard | r.round_bit | r.sticky;
    case (r.round_mode)
      RM_RNE:  return r.guard & (r.round_bit | r.sticky | r.mantissa[0]);
      RM_RDN:  return r.sign & inexact;
      RM_RUP:  return !r.sign & inexact;
      RM_RMM:  return r.guard;
      default: return 1'b0;
    endcase
  endfunction

  // Exponent+mantissa after rounding; a mantissa carry ripples into the exponent field.
  function automatic logic [30:0] basilisk_round_mag(fpu_result_t r);
    return {r.exponent, r.mantissa} + {30'd0, basilisk_round_up(r)};
  endfunction

  function automatic rv32_reg_value_t basilisk_round_result(fpu_result_t r);
    logic [30:0] mag;
    logic        to_inf;
    if (r.is_nan) return 32'h7FC0_0000;
    if (r.exponent == 8'hFF) return {r.sign, 8'hFF, 23'd0};
    mag    = basilisk_round_mag(r);
    to_inf = (r.round_mode == RM_RNE) || (r.round_mode == RM_RMM) ||
             ((r.round_mode == RM_RDN) && r.sign) || ((r.round_mode == RM_RUP) && !r.sign);
    if (mag[30:23] == 8'hFF) return to_inf ? {r.sign, 8'hFF, 23'd0} : {r.sign, 8'hFE, {23{1'b1}}};
    return {r.sign, mag};
  endfunction

  function automatic basilisk_fflags_t basilisk_round_flags(fpu_result_t r, logic is_div);
    basilisk_fflags_t f;
    logic [30:0]      mag;
    logic             inexact;
    f       = '0;
    mag     = basilisk_round_mag(r);
    inexact = r.guard | r.round_bit | r.sticky;
    if (r.is_nan) begin
      f.nv = r.is_snan;
    end else if (r.exponent != 8'hFF) begin
      f.of = (mag[30:23] == 8'hFF);
      f.nx = inexact | f.of;
      f.uf = (mag[30:23] == 8'h00) & inexact;
    end
    f.dz = is_div & r.div_zero;
    return f;
  endfunction

endpackage

// File: rtl/basilisk_writeback_arbiter.sv
// Round-robin arbiter: one-hot grant to the requester nearest the priority pointer (cyclic upward);
// the pointer moves past the granted index on advance.
module basilisk_writeback_arbiter #(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d, grant_idx, idx;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
    ptr_d = ptr_q;
    if (advance) ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + PtrW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/basilisk_writeback.sv
// basilisk FPU writeback: arbitrates FPU and raw streams, rounds FPU results to single precision,
// registers one result per cycle. Optional sticky flags via BASILISK_WRITEBACK_FFLAGS_EN.
module basilisk_writeback
  import basilisk_writeback_pkg::*;
#(
  parameter int unsigned NUM_FPU_INPUTS = 4,
  parameter int unsigned NUM_INPUTS     = NUM_FPU_INPUTS + 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [NUM_FPU_INPUTS-1:0]                             fpu_valid,
  output logic [NUM_FPU_INPUTS-1:0]                             fpu_ready,
  input  logic [NUM_FPU_INPUTS*$bits(basilisk_result_t)-1:0]    fpu_data,
  input  logic                                                  raw_valid,
  output logic                                                  raw_ready,
  input  logic [$bits(basilisk_writeback_result_t)-1:0]         raw_data,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [$bits(basilisk_writeback_result_t)-1:0]         out_data,
  output logic                                                  busy
`ifdef BASILISK_WRITEBACK_FFLAGS_EN
  ,
  input  logic                                                  fflags_clear,
  output logic [4:0]                                            fflags
`endif
);

  localparam int unsigned ResW   = $bits(basilisk_result_t);
  localparam int unsigned RawIdx = NUM_FPU_INPUTS;

  basilisk_result_t           fpu_res [NUM_FPU_INPUTS];
  basilisk_result_t           sel_res;
  basilisk_writeback_result_t out_d, out_q;
  logic [NUM_INPUTS-1:0]      req, grant;
  logic                       load_ok, xfer, out_valid_q;

  for (genvar i = 0; i < NUM_FPU_INPUTS; i++) begin : g_unpack
    assign fpu_res[i] = fpu_data[i*ResW +: ResW];
  end

  assign req     = {raw_valid, fpu_valid};
  assign load_ok = !out_valid_q || out_ready;
  // Grant is non-zero exactly when some request is up, so |req stands in for |grant.
  assign xfer    = rst && load_ok && (|req);

  basilisk_writeback_arbiter #(
    .N(NUM_INPUTS)
  ) u_arbiter (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .advance(xfer),
    .grant  (grant)
  );

  assign fpu_ready = (rst && load_ok) ? grant[NUM_FPU_INPUTS-1:0] : '0;
  assign raw_ready = rst && load_ok && grant[RawIdx];

  always_comb begin
    sel_res = '0;
    for (int unsigned i = 0; i < NUM_FPU_INPUTS; i++) begin
      if (grant[i]) sel_res = fpu_res[i];
    end
    out_d = raw_data;
    if (!grant[RawIdx]) begin
      out_d.dest_reg_addr    = sel_res.dest_reg_addr;
      out_d.dest_offset_addr = sel_res.dest_offset_addr;
      out_d.value            = basilisk_round_result(sel_res);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (load_ok) begin
      out_valid_q <= xfer;
      if (xfer) out_q <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = out_valid_q || (|fpu_valid) || raw_valid;

`ifdef BASILISK_WRITEBACK_FFLAGS_EN
  basilisk_fflags_t fflags_q;
  logic             fpu_xfer;

  assign fpu_xfer = xfer && !grant[RawIdx];

  always_ff @(posedge clk) begin
    if (!rst)              fflags_q <= '0;
    else if (fflags_clear) fflags_q <= '0;
    else if (fpu_xfer)     fflags_q <= fflags_q | basilisk_round_flags(sel_res, grant[STREAM_DIV]);
  end

  assign fflags = fflags_q;
`endif

endmodule

// File: tb/tb_basilisk_writeback.sv
// Self-checking bench for basilisk_writeback: directed rounding table, multi-cycle sequences and
// randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_basilisk_writeback;
  import basilisk_writeback_pkg::*;

  localparam int NF = 4;
  localparam int NI = 5;
  localparam int RW = $bits(basilisk_result_t);
  localparam int WW = $bits(basilisk_writeback_result_t);

  logic clk = 1'b0;
  logic rst = 1'b0;
  basilisk_result_t           src [NF];
  basilisk_writeback_result_t raw_src;
  logic [NF-1:0]    fpu_valid, fpu_ready;
  logic [NF*RW-1:0] fpu_data;
  logic             raw_valid, raw_ready, out_valid, out_ready, busy;
  logic [WW-1:0]    raw_data, out_data;
  logic [NI-1:0]    all_valid, all_ready;
`ifdef BASILISK_WRITEBACK_FFLAGS_EN
  logic       fflags_clear;
  logic [4:0] fflags;
`endif

  assign fpu_data  = {src[3], src[2], src[1], src[0]};
  assign raw_data  = raw_src;
  assign all_valid = {raw_valid, fpu_valid};
  assign all_ready = {raw_ready, fpu_ready};

  always #5 clk = ~clk;

  basilisk_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .fpu_valid   (fpu_valid),
    .fpu_ready   (fpu_ready),
    .fpu_data    (fpu_data),
    .raw_valid   (raw_valid),
    .raw_ready   (raw_ready),
    .raw_data    (raw_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
`ifdef BASILISK_WRITEBACK_FFLAGS_EN
    ,
    .fflags_clear(fflags_clear),
    .fflags      (fflags)
`endif
  );

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  logic m_valid = 1'b0;
  logic [WW-1:0] m_data = '0;
  logic [4:0] m_flags = '0;
  int last_grant;
  logic [NI-1:0] act_ready;

  task automatic check(string name, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, want);
    end
  endtask

  // Rounded magnitude (exponent:mantissa as one integer) before overflow handling.
  function automatic longint ref_mag(basilisk_result_t r);
    longint mag;
    int     rem;
    bit     up;
    mag = longint'({r.exponent, r.mantissa});
    rem = int'({r.guard, r.round_bit, r.sticky});
    case (r.round_mode)
      RM_RNE:  up = (rem > 4) || (rem == 4 && (mag % 2) == 1);
      RM_RDN:  up = r.sign && rem != 0;
      RM_RUP:  up = !r.sign && rem != 0;
      RM_RMM:  up = rem >= 4;
      default: up = 1'b0;
    endcase
    return mag + (up ? 1 : 0);
  endfunction

  function automatic logic [31:0] ref_round(basilisk_result_t r);
    longint mag;
    bit     to_inf;
    if (r.is_nan) return 32'h7FC0_0000;
    if (r.exponent == 8'hFF) return {r.sign, 31'h7F80_0000};
    mag = ref_mag(r);
    if (mag >= 64'h7F80_0000) begin
      to_inf = r.round_mode == RM_RNE || r.round_mode == RM_RMM ||
               (r.round_mode == RM_RDN && r.sign) || (r.round_mode == RM_RUP && !r.sign);
      return to_inf ? {r.sign, 31'h7F80_0000} : {r.sign, 31'h7F7F_FFFF};
    end
    return {r.sign, mag[30:0]};
  endfunction

  // Flag bits: [4]=NV [3]=DZ [2]=OF [1]=UF [0]=NX
  function automatic logic [4:0] ref_flags(basilisk_result_t r, bit is_div);
    logic [4:0] f;
    longint     mag;
    bit         inexact, of;
    f = '0;
    inexact = {r.guard, r.round_bit, r.sticky} != 3'd0;
    mag = ref_mag(r);
    if (r.is_nan) begin
      f[4] = r.is_snan;
    end else if (r.exponent != 8'hFF) begin
      of   = mag >= 64'h7F80_0000;
      f[2] = of;
      f[0] = inexact || of;
      f[1] = (mag >> 23) == 0 && inexact;
    end
    f[3] = is_div && r.div_zero;
    return f;
  endfunction

  function automatic logic [WW-1:0] ref_value(int g);
    if (g == NF) return raw_src;
    return {src[g].dest_reg_addr, src[g].dest_offset_addr, ref_round(src[g])};
  endfunction

  // Winner is the pending stream at the smallest cyclic distance above the pointer.
  function automatic int pick();
    int best = -1;
    int bd   = NI;
    for (int i = 0; i < NI; i++) begin
      if (all_valid[i] && ((i - m_ptr + NI) % NI) < bd) begin
        bd   = (i - m_ptr + NI) % NI;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic step();
    logic          load_ok;
    int            g;
    logic [NI-1:0] er;
    @(negedge clk);
    load_ok = !m_valid || out_ready;
    g  = pick();
    er = '0;
    if (rst && load_ok && g >= 0) er[g] = 1'b1;
    act_ready = all_ready;
    check("ready", act_ready, er);
    if (!(rst && load_ok)) g = -1;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ptr   = 0;
      m_flags = '0;
      g       = -1;
    end else begin
`ifdef BASILISK_WRITEBACK_FFLAGS_EN
      if (fflags_clear) m_flags = '0;
      else if (g >= 0 && g < NF) m_flags = m_flags | ref_flags(src[g], g == 2);
`endif
      if (load_ok) begin
        m_valid = g >= 0;
        if (g >= 0) begin
          m_data = ref_value(g);
          m_ptr  = (g + 1) % NI;
        end
      end
    end
    last_grant = g;
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
`ifdef BASILISK_WRITEBACK_FFLAGS_EN
    check("fflags", fflags, m_flags);
`endif
  endtask

  task automatic clear_grant();
    if (last_grant >= 0 && last_grant < NF) fpu_valid[last_grant] = 1'b0;
    else if (last_grant == NF) raw_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 30 && all_valid != '0; k++) begin
      step();
      clear_grant();
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  function automatic basilisk_result_t rand_res();
    basilisk_result_t r;
    r.dest_reg_addr    = 5'($urandom);
    r.dest_offset_addr = 2'($urandom);
    r.sign             = 1'($urandom);
    case ($urandom_range(0, 5))
      0:       r.exponent = 8'hFE;
      1:       r.exponent = 8'h00;
      2:       r.exponent = 8'hFF;
      default: r.exponent = 8'($urandom);
    endcase
    r.mantissa   = ($urandom_range(0, 1) == 1) ? '1 : 23'($urandom);
    r.guard      = 1'($urandom);
    r.round_bit  = 1'($urandom);
    r.sticky     = 1'($urandom);
    r.round_mode = 3'($urandom_range(0, 4));
    r.is_nan     = $urandom_range(0, 9) == 0;
    r.is_snan    = r.is_nan && ($urandom_range(0, 1) == 1);
    r.div_zero   = $urandom_range(0, 5) == 0;
    return r;
  endfunction

  function automatic basilisk_result_t mk(bit s, logic [7:0] e, logic [22:0] m, logic [2:0] grs,
                                          logic [2:0] rm, bit nan);
    basilisk_result_t r;
    r = '0;
    r.dest_reg_addr = 5'd5;
    r.sign          = s;
    r.exponent      = e;
    r.mantissa      = m;
    {r.guard, r.round_bit, r.sticky} = grs;
    r.round_mode    = rm;
    r.is_nan        = nan;
    return r;
  endfunction

  // Valid must hold and data must stay put until the handshake completes.
  logic [NI-1:0]    pv = '0, pr = '0;
  logic [NF*RW-1:0] pfd = '0;
  logic [WW-1:0]    prd = '0;
  logic             prst = 1'b0;
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (prst && rst && pv[i] && !pr[i]) begin
        assert (all_valid[i]) else $error("FAIL handshake: valid %0d dropped before transfer", i);
        if (i < NF) begin
          assert (fpu_data[i*RW +: RW] == pfd[i*RW +: RW])
            else $error("FAIL handshake: data %0d changed before transfer", i);
        end else begin
          assert (raw_data == prd) else $error("FAIL handshake: raw data changed before transfer");
        end
      end
    end
    pv   <= all_valid;
    pr   <= all_ready;
    pfd  <= fpu_data;
    prd  <= raw_data;
    prst <= rst;
  end

  typedef struct {
    basilisk_result_t in;
    logic [31:0]      want;
  } vec_t;
  vec_t vecs [13];

  initial begin
    logic [WW-1:0] held;
    for (int i = 0; i < NF; i++) src[i] = '0;
    raw_src   = '0;
    fpu_valid = '0;
    raw_valid = 1'b0;
    out_ready = 1'b1;
`ifdef BASILISK_WRITEBACK_FFLAGS_EN
    fflags_clear = 1'b0;
`endif

    vecs[0]  = '{mk(0, 8'h80, 23'h400000, 3'b000, RM_RNE, 0), 32'h4040_0000};
    vecs[1]  = '{mk(0, 8'h7F, '1, 3'b100, RM_RNE, 0), 32'h4000_0000};
    vecs[2]  = '{mk(0, 8'hFE, '1, 3'b100, RM_RNE, 0), 32'h7F80_0000};
    vecs[3]  = '{mk(0, 8'hFE, '1, 3'b100, RM_RTZ, 0), 32'h7F7F_FFFF};
    vecs[4]  = '{mk(0, 8'h12, 23'h1234, 3'b000, RM_RNE, 1), 32'h7FC0_0000};
    vecs[5]  = '{mk(0, 8'h7F, 23'd0, 3'b100, RM_RNE, 0), 32'h3F80_0000};
    vecs[6]  = '{mk(0, 8'h7F, 23'd0, 3'b100, RM_RMM, 0), 32'h3F80_0001};
    vecs[7]  = '{mk(1, 8'h7F, 23'd0, 3'b001, RM_RDN, 0), 32'hBF80_0001};
    vecs[8]  = '{mk(1, 8'h7F, 23'd0, 3'b001, RM_RUP, 0), 32'hBF80_0000};
    vecs[9]  = '{mk(0, 8'h7F, 23'd0, 3'b001, RM_RUP, 0), 32'h3F80_0001};
    vecs[10] = '{mk(1, 8'hFE, '1, 3'b100, RM_RUP, 0), 32'hFF7F_FFFF};
    vecs[11] = '{mk(1, 8'hFE, '1, 3'b100, RM_RDN, 0), 32'hFF80_0000};
    vecs[12] = '{mk(0, 8'h7F, 23'h1, 3'b110, RM_RTZ, 0), 32'h3F80_0001};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed rounding table on the add stream
    foreach (vecs[i]) begin
      src[0]    = vecs[i].in;
      fpu_valid = 4'b0001;
      step();
      fpu_valid = '0;
      check($sformatf("vec%0d", i), out_data, {5'd5, 2'd0, vecs[i].want});
      step();
    end

    // All streams requesting from ptr=0: strict rotation, no bubbles
    do_reset();
    for (int i = 0; i < NF; i++) src[i] = rand_res();
    raw_src   = {5'($urandom), 2'($urandom), 32'($urandom)};
    fpu_valid = '1;
    raw_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_order", act_ready, 64'(1) << (i % NI));
      check("rr_no_bubble", out_valid, 1'b1);
      if (last_grant >= 0 && last_grant < NF) src[last_grant] = rand_res();
      else if (last_grant == NF) raw_src = {5'($urandom), 2'($urandom), 32'($urandom)};
    end
    drain();

    // Backpressure with mult and raw pending, then in-order drain
    do_reset();
    src[0]    = rand_res();
    fpu_valid = 4'b0001;
    step();
    fpu_valid = '0;
    held      = m_data;
    out_ready = 1'b0;
    src[1]    = rand_res();
    fpu_valid = 4'b0010;
    raw_src   = {5'd9, 2'd1, 32'hDEAD_BEEF};
    raw_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_readies", act_ready, '0);
      check("bp_hold", out_data, held);
    end
    out_ready = 1'b1;
    step();
    check("bp_mult_first", act_ready, 5'b00010);
    fpu_valid = '0;
    step();
    check("bp_raw_second", act_ready, 5'b10000);
    check("raw_pass", out_data, {5'd9, 2'd1, 32'hDEAD_BEEF});
    raw_valid = 1'b0;
    step();

    // Reset with a result sitting in the output register
    src[2]    = rand_res();
    fpu_valid = 4'b0100;
    step();
    fpu_valid = '0;
    out_ready = 1'b0;
    rst       = 1'b0;
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NF; i++) src[i] = rand_res();
    fpu_valid = '1;
    raw_valid = 1'b1;
    step();
    check("rst_first_grant", act_ready, 5'b00001);
    clear_grant();
    drain();

`ifdef BASILISK_WRITEBACK_FFLAGS_EN
    do_reset();
    src[0]    = mk(0, 8'h7F, 23'd0, 3'b101, RM_RNE, 0);
    fpu_valid = 4'b0001;
    step();
    fpu_valid = '0;
    check("ff_nx", fflags, 5'b00001);
    src[2]          = mk(0, 8'h81, 23'd0, 3'b000, RM_RNE, 0);
    src[2].div_zero = 1'b1;
    fpu_valid       = 4'b0100;
    fflags_clear    = 1'b1;
    step();
    fflags_clear = 1'b0;
    check("ff_clear_wins", fflags, 5'b00000);
    step();
    check("ff_dz", fflags, 5'b01000);
    fpu_valid = '0;
    step();
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      out_ready = $urandom_range(0, 3) != 0;
`ifdef BASILISK_WRITEBACK_FFLAGS_EN
      fflags_clear = $urandom_range(0, 15) == 0;
`endif
      for (int i = 0; i < NF; i++) begin
        if (!fpu_valid[i] && $urandom_range(0, 1) == 1) begin
          src[i]       = rand_res();
          fpu_valid[i] = 1'b1;
        end
      end
      if (!raw_valid && $urandom_range(0, 2) == 0) begin
        raw_src   = {5'($urandom), 2'($urandom), 32'($urandom)};
        raw_valid = 1'b1;
      end
      step();
      clear_grant();
    end
`ifdef BASILISK_WRITEBACK_FFLAGS_EN
    fflags_clear = 1'b0;
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
